// File: rtl/des_ahb_master.sv
// Non-pipelined AHB-Lite master that runs one Triple-DES operation on the 3DES slave.
// Optional key cache enabled by defining DES_KEY_CACHE_EN.
module des_ahb_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned POLL_MAX  = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start_i,
  input  logic        decrypt_i,
  input  logic [63:0] key1_i,
  input  logic [63:0] key2_i,
  input  logic [63:0] key3_i,
  input  logic [63:0] data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [63:0] data_o,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [63:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [63:0] HRDATA
);

  localparam int unsigned PollW = $clog2(POLL_MAX + 1);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;

  localparam logic [2:0] StepKey1   = 3'd0;
  localparam logic [2:0] StepKey2   = 3'd1;
  localparam logic [2:0] StepKey3   = 3'd2;
  localparam logic [2:0] StepDin    = 3'd3;
  localparam logic [2:0] StepCtrl   = 3'd4;
  localparam logic [2:0] StepStatus = 3'd5;
  localparam logic [2:0] StepDout   = 3'd6;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StFinish
  } state_e;

  state_e             r_state, w_state_d;
  logic [2:0]         r_step, w_step_d;
  logic [PollW-1:0]   r_poll, w_poll_d;
  logic [PollW-1:0]   w_poll_inc;
  logic               r_dec;
  logic [63:0]        r_key1, r_key2, r_key3, r_din;
  logic [63:0]        r_dout;
  logic               r_err;
  logic               w_accept, w_abort, w_capture;
  logic [2:0]         w_first_step;
  logic [31:0]        w_offset;
  logic [63:0]        w_wdata;
  logic               w_in_xfer, w_is_write;

`ifdef DES_KEY_CACHE_EN
  logic [63:0] r_ckey1, r_ckey2, r_ckey3;
  logic        r_keys_valid;
  logic        w_key_hit, w_keys_written;

  assign w_key_hit = r_keys_valid && (key1_i == r_ckey1) && (key2_i == r_ckey2) &&
                     (key3_i == r_ckey3);
  assign w_first_step = w_key_hit ? StepDin : StepKey1;
  // Cache is only trusted once all three key writes have landed on the slave.
  assign w_keys_written = (r_state == StData) && HREADY && !HRESP && (r_step == StepKey3);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_ckey1      <= '0;
      r_ckey2      <= '0;
      r_ckey3      <= '0;
      r_keys_valid <= 1'b0;
    end else if (w_abort) begin
      r_keys_valid <= 1'b0;
    end else if (w_keys_written) begin
      r_ckey1      <= r_key1;
      r_ckey2      <= r_key2;
      r_ckey3      <= r_key3;
      r_keys_valid <= 1'b1;
    end
  end
`else
  assign w_first_step = StepKey1;
`endif

  assign w_poll_inc = r_poll + PollW'(1);

  always_comb begin
    w_state_d = r_state;
    w_step_d  = r_step;
    w_poll_d  = r_poll;
    w_accept  = 1'b0;
    w_abort   = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          w_accept  = 1'b1;
          w_state_d = StAddr;
          w_step_d  = w_first_step;
          w_poll_d  = '0;
        end
      end
      StAddr: w_state_d = StData;
      StData: begin
        if (HRESP) begin
          w_abort   = 1'b1;
          w_state_d = StIdle;
        end else if (HREADY) begin
          if (r_step == StepStatus) begin
            if (HRDATA[0]) begin
              w_step_d  = StepDout;
              w_state_d = StAddr;
            end else if (w_poll_inc == PollW'(POLL_MAX)) begin
              w_abort   = 1'b1;
              w_state_d = StIdle;
            end else begin
              w_poll_d  = w_poll_inc;
              w_state_d = StAddr;
            end
          end else if (r_step == StepDout) begin
            w_capture = 1'b1;
            w_state_d = StFinish;
          end else begin
            w_step_d  = r_step + 3'd1;
            w_state_d = StAddr;
          end
        end
      end
      StFinish: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= StIdle;
      r_step  <= StepKey1;
      r_poll  <= '0;
      r_err   <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_d;
      r_step  <= w_step_d;
      r_poll  <= w_poll_d;
      r_err   <= w_abort;
      if (w_capture) begin
        r_dout <= HRDATA;
      end
    end
  end

  // Operands are frozen at accept so the client may change its inputs while busy.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dec  <= 1'b0;
      r_key1 <= '0;
      r_key2 <= '0;
      r_key3 <= '0;
      r_din  <= '0;
    end else if (w_accept) begin
      r_dec  <= decrypt_i;
      r_key1 <= key1_i;
      r_key2 <= key2_i;
      r_key3 <= key3_i;
      r_din  <= data_i;
    end
  end

  always_comb begin
    w_offset = 32'h0000_0000;
    w_wdata  = '0;
    unique case (r_step)
      StepKey1: begin
        w_offset = 32'h0000_0000;
        w_wdata  = r_key1;
      end
      StepKey2: begin
        w_offset = 32'h0000_0008;
        w_wdata  = r_key2;
      end
      StepKey3: begin
        w_offset = 32'h0000_0010;
        w_wdata  = r_key3;
      end
      StepDin: begin
        w_offset = 32'h0000_0018;
        w_wdata  = r_din;
      end
      StepCtrl: begin
        w_offset = 32'h0000_0030;
        w_wdata  = {62'b0, 1'b1, r_dec};
      end
      StepStatus: w_offset = 32'h0000_0020;
      StepDout:   w_offset = 32'h0000_0028;
      default:    w_offset = 32'h0000_0000;
    endcase
  end

  assign w_in_xfer  = (r_state == StAddr) || (r_state == StData);
  assign w_is_write = (r_step < StepStatus);

  assign HTRANS    = (r_state == StAddr) ? TransNonseq : TransIdle;
  assign HADDR     = w_in_xfer ? (BASE_ADDR + w_offset) : 32'h0000_0000;
  assign HWRITE    = w_in_xfer && w_is_write;
  assign HWDATA    = ((r_state == StData) && w_is_write) ? w_wdata : 64'h0;
  assign HSIZE     = 3'b011;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

  assign busy_o = (r_state != StIdle);
  assign done_o = (r_state == StFinish);
  assign err_o  = r_err;
  assign data_o = r_dout;

endmodule

// File: tb/tb_des_ahb_master.sv
// Bench for des_ahb_master: directed vector table, reset and cache sequences, and randomized
// operations checked against a transaction-level model of the expected bus trace.
module tb_des_ahb_master;

  localparam int unsigned PollMax = 4;
  localparam logic [31:0] Base    = 32'h0000_0000;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        start_i, decrypt_i;
  logic [63:0] key1_i, key2_i, key3_i, data_i;
  logic        busy_o, done_o, err_o;
  logic [63:0] data_o;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [63:0] HWDATA;
  logic        HREADY, HRESP;
  logic [63:0] HRDATA;

  always #5 HCLK = ~HCLK;

  des_ahb_master #(.BASE_ADDR(Base), .POLL_MAX(PollMax)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start_i(start_i), .decrypt_i(decrypt_i),
    .key1_i(key1_i), .key2_i(key2_i), .key3_i(key3_i), .data_i(data_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .data_o(data_o),
    .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [63:0] wdata;
  } xfer_t;

  typedef struct {
    logic [63:0] k1, k2, k3, din, res;
    logic        dec;
    int          nd, wait_idx, wait_n, err_idx, x_done, x_err, x_nxfer, x_nstat;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  // Slave behaviour for the current operation.
  int          cfg_waits[16];
  int          cfg_nd, cfg_err_idx;
  logic [63:0] cfg_res;

  // Observations of the current operation.
  xfer_t act_q[$];
  int    obs_done, obs_err, n_done, n_err, viol;
  logic  busy1, busy_end, timed_out;

  // Reference model state.
  xfer_t       exp_q[$];
  int          exp_done, exp_err;
  logic [63:0] m_data_o = '0;
  logic        m_kv = 1'b0;
  logic [63:0] m_k1, m_k2, m_k3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int nd, input int wait_idx, input int wait_n, input int err_idx,
                         input logic [63:0] res);
    for (int j = 0; j < 16; j++) cfg_waits[j] = 0;
    if (wait_idx >= 0) cfg_waits[wait_idx] = wait_n;
    cfg_nd      = nd;
    cfg_err_idx = err_idx;
    cfg_res     = res;
  endtask

  function automatic xfer_t mk(input logic [31:0] off, input logic wr, input logic [63:0] wd);
    xfer_t x;
    x.addr  = Base + off;
    x.write = wr;
    x.wdata = wd;
    return x;
  endfunction

  // Expected trace: a list of transfers, each costing 2 cycles plus its wait states.
  task automatic model_op(input logic [63:0] k1, k2, k3, din, input logic dec);
    logic skip, to, aborted;
    int   n_st, cyc;
    exp_q.delete();
    skip = 1'b0;
`ifdef DES_KEY_CACHE_EN
    skip = m_kv && (k1 == m_k1) && (k2 == m_k2) && (k3 == m_k3);
`endif
    if (!skip) begin
      exp_q.push_back(mk(32'h00, 1'b1, k1));
      exp_q.push_back(mk(32'h08, 1'b1, k2));
      exp_q.push_back(mk(32'h10, 1'b1, k3));
    end
    exp_q.push_back(mk(32'h18, 1'b1, din));
    exp_q.push_back(mk(32'h30, 1'b1, {62'b0, 1'b1, dec}));
    to   = (cfg_nd >= int'(PollMax));
    n_st = to ? int'(PollMax) : cfg_nd + 1;
    for (int i = 0; i < n_st; i++) exp_q.push_back(mk(32'h20, 1'b0, 64'h0));
    if (!to) exp_q.push_back(mk(32'h28, 1'b0, 64'h0));
    exp_done = -1;
    exp_err  = -1;
    aborted  = 1'b0;
    cyc      = 1;
    for (int i = 0; i < exp_q.size(); i++) begin
      cyc += 2 + cfg_waits[i];
      if (i == cfg_err_idx) begin
        aborted = 1'b1;
        while (exp_q.size() > i + 1) exp_q.pop_back();
        break;
      end
    end
    if (aborted || to) begin
      exp_err = cyc;
      m_kv    = 1'b0;
    end else begin
      exp_done = cyc;
      m_data_o = cfg_res;
      if (!skip) begin
        m_kv = 1'b1;
        m_k1 = k1;
        m_k2 = k2;
        m_k3 = k3;
      end
    end
  endtask

  // Starts an operation at the current falling edge and plays the slave until the
  // cycle after done_o, or the err_o cycle. Cycle 0 is the accept cycle.
  task automatic run_op(input logic [63:0] k1, k2, k3, din, input logic dec);
    xfer_t       rec;
    logic        dp, dp_wr, fin;
    logic [31:0] dp_addr;
    int          dp_idx, wl, xi, st_seen, end_c;
    act_q.delete();
    obs_done = -1; obs_err = -1; n_done = 0; n_err = 0; viol = 0;
    busy1 = 1'b0; busy_end = 1'b1; timed_out = 1'b0;
    dp = 1'b0; dp_wr = 1'b0; dp_addr = '0; dp_idx = 0; wl = 0; xi = 0; st_seen = 0;
    end_c = -1; fin = 1'b0;
    key1_i = k1; key2_i = k2; key3_i = k3; data_i = din; decrypt_i = dec;
    start_i = 1'b1;
    @(posedge HCLK);
    for (int c = 1; c <= 300 && !fin; c++) begin
      @(negedge HCLK);
      // A start while busy must be ignored, and operands may change after accept.
      start_i = (c == 2);
      if (c == 2) begin
        key1_i = ~k1;
        data_i = ~din;
      end
      if (c == 1) busy1 = busy_o;
      if (done_o) begin n_done++; if (obs_done < 0) obs_done = c; end
      if (err_o) begin n_err++; if (obs_err < 0) obs_err = c; end
      if (end_c < 0 && done_o) end_c = c + 1;
      if (end_c < 0 && err_o) end_c = c;
      if (c == end_c) begin
        busy_end = busy_o;
        fin = 1'b1;
      end
      if (HSIZE != 3'b011 || HBURST != 3'b000 || HPROT != 4'b0011 || HMASTLOCK) viol++;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = '0;
      if (dp) begin
        if (HTRANS != 2'b00) viol++;
        if (!dp_wr && HWDATA != 64'h0) viol++;
        if (wl > 0) begin
          HREADY = 1'b0;
          wl--;
        end else begin
          rec.addr  = dp_addr;
          rec.write = dp_wr;
          rec.wdata = dp_wr ? HWDATA : 64'h0;
          act_q.push_back(rec);
          if (dp_idx == cfg_err_idx) HRESP = 1'b1;
          else if (!dp_wr && dp_addr == Base + 32'h20) HRDATA = {63'b0, st_seen >= cfg_nd};
          else if (!dp_wr) HRDATA = cfg_res;
          if (!dp_wr && dp_addr == Base + 32'h20) st_seen++;
          dp = 1'b0;
        end
      end else begin
        if (HWDATA != 64'h0) viol++;
        if (HTRANS == 2'b10) begin
          dp      = 1'b1;
          dp_addr = HADDR;
          dp_wr   = HWRITE;
          dp_idx  = xi;
          wl      = (xi < 16) ? cfg_waits[xi] : 0;
          xi++;
        end else if (HTRANS != 2'b00) begin
          viol++;
        end
      end
    end
    start_i = 1'b0;
    if (!fin) timed_out = 1'b1;
  endtask

  task automatic check_op(input string tag);
    int n;
    chk({tag, " cycle budget exceeded"}, timed_out, 1'b0);
    chk({tag, " transfer count"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s xfer%0d addr", tag, i), act_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s xfer%0d write", tag, i), act_q[i].write, exp_q[i].write);
      chk($sformatf("%s xfer%0d wdata", tag, i), act_q[i].wdata, exp_q[i].wdata);
    end
    chk({tag, " done cycle"}, obs_done, exp_done);
    chk({tag, " err cycle"}, obs_err, exp_err);
    chk({tag, " done pulses"}, n_done, (exp_done >= 0) ? 1 : 0);
    chk({tag, " err pulses"}, n_err, (exp_err >= 0) ? 1 : 0);
    chk({tag, " data_o"}, data_o, m_data_o);
    chk({tag, " busy at cycle 1"}, busy1, 1'b1);
    chk({tag, " busy after end"}, busy_end, 1'b0);
    chk({tag, " protocol violations"}, viol, 0);
  endtask

  function automatic int count_status();
    int n = 0;
    foreach (act_q[i]) if (!act_q[i].write && act_q[i].addr == Base + 32'h20) n++;
    return n;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[4];
    logic [63:0] k1, k2, k3, din, res;
    logic        dec;
    int          r;

    vecs[0] = '{64'h0123456789ABCDEF, 64'h23456789ABCDEF01, 64'h456789ABCDEF0123,
                64'h4E6F772069732074, 64'h3FA40E8A984D4815, 1'b0, 0, -1, 0, -1, 15, -1, 7, 1};
    vecs[1] = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
                64'hAAAAAAAA55555555, 64'h5555AAAA5555AAAA, 1'b1, 2, 3, 3, -1, 22, -1, 9, 3};
    vecs[2] = '{64'h4444444444444444, 64'h5555555555555555, 64'h6666666666666666,
                64'h0F0F0F0F0F0F0F0F, 64'hDEADBEEFDEADBEEF, 1'b0, 0, -1, 0, 1, -1, 5, 2, 0};
    vecs[3] = '{64'h7777777777777777, 64'h8888888888888888, 64'h9999999999999999,
                64'hF0F0F0F0F0F0F0F0, 64'hCAFEF00DCAFEF00D, 1'b1, 10, -1, 0, -1, -1, 19, 9, 4};

    HRESET = 1'b1; start_i = 1'b0; decrypt_i = 1'b0;
    key1_i = '0; key2_i = '0; key3_i = '0; data_i = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    set_cfg(0, -1, 0, -1, 64'h0);
    repeat (3) @(negedge HCLK);
    chk("reset HTRANS", HTRANS, 2'b00);
    chk("reset HADDR", HADDR, 32'h0);
    chk("reset HWRITE", HWRITE, 1'b0);
    chk("reset HWDATA", HWDATA, 64'h0);
    chk("reset busy_o", busy_o, 1'b0);
    chk("reset done_o", done_o, 1'b0);
    chk("reset err_o", err_o, 1'b0);
    chk("reset data_o", data_o, 64'h0);
    HRESET = 1'b0;
    @(negedge HCLK);

    for (int i = 0; i < 4; i++) begin
      set_cfg(vecs[i].nd, vecs[i].wait_idx, vecs[i].wait_n, vecs[i].err_idx, vecs[i].res);
      model_op(vecs[i].k1, vecs[i].k2, vecs[i].k3, vecs[i].din, vecs[i].dec);
      run_op(vecs[i].k1, vecs[i].k2, vecs[i].k3, vecs[i].din, vecs[i].dec);
      check_op($sformatf("vec%0d", i));
      chk($sformatf("vec%0d table done cycle", i), obs_done, vecs[i].x_done);
      chk($sformatf("vec%0d table err cycle", i), obs_err, vecs[i].x_err);
      chk($sformatf("vec%0d table transfers", i), act_q.size(), vecs[i].x_nxfer);
      chk($sformatf("vec%0d table status reads", i), count_status(), vecs[i].x_nstat);
    end

    // Reset during the CTRL data phase, then a fresh full operation.
    set_cfg(0, -1, 0, -1, 64'h0);
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    key1_i = 64'hA1; key2_i = 64'hA2; key3_i = 64'hA3; data_i = 64'hA4; decrypt_i = 1'b0;
    start_i = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    start_i = 1'b0;
    repeat (9) @(negedge HCLK);
    chk("pre-reset CTRL addr", HADDR, Base + 32'h30);
    chk("pre-reset CTRL wdata", HWDATA, 64'h2);
    HRESET = 1'b1;
    #1;
    chk("mid-reset HTRANS", HTRANS, 2'b00);
    chk("mid-reset busy_o", busy_o, 1'b0);
    chk("mid-reset HWDATA", HWDATA, 64'h0);
    @(negedge HCLK);
    HRESET   = 1'b0;
    m_data_o = '0;
    m_kv     = 1'b0;
    chk("post-reset data_o", data_o, 64'h0);
    set_cfg(0, -1, 0, -1, 64'h1234_5678_9ABC_DEF0);
    model_op(64'hA1, 64'hA2, 64'hA3, 64'hA4, 1'b0);
    run_op(64'hA1, 64'hA2, 64'hA3, 64'hA4, 1'b0);
    check_op("after reset");

    k1 = '0; k2 = '0; k3 = '0;
    for (int i = 0; i < 24; i++) begin
      if (i == 0 || $urandom_range(0, 2) != 0) begin
        k1 = {$urandom(), $urandom()};
        k2 = {$urandom(), $urandom()};
        k3 = {$urandom(), $urandom()};
      end
      din = {$urandom(), $urandom()};
      res = {$urandom(), $urandom()};
      dec = 1'($urandom_range(0, 1));
      set_cfg(0, -1, 0, -1, res);
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 16; j++) cfg_waits[j] = int'($urandom_range(0, 2));
      end
      r = int'($urandom_range(0, 9));
      cfg_nd = (r < 7) ? (r % 3) : ((r == 7) ? int'(PollMax) - 1 : int'(PollMax) + 1);
      cfg_err_idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1;
      model_op(k1, k2, k3, din, dec);
      run_op(k1, k2, k3, din, dec);
      check_op($sformatf("rand%0d", i));
    end

`ifdef DES_KEY_CACHE_EN
    set_cfg(0, -1, 0, -1, 64'h0BAD_F00D_0BAD_F00D);
    model_op(64'hC1, 64'hC2, 64'hC3, 64'hD1, 1'b0);
    run_op(64'hC1, 64'hC2, 64'hC3, 64'hD1, 1'b0);
    check_op("cache fill");
    chk("cache fill done cycle", obs_done, 15);
    model_op(64'hC1, 64'hC2, 64'hC3, 64'hD2, 1'b1);
    run_op(64'hC1, 64'hC2, 64'hC3, 64'hD2, 1'b1);
    check_op("cache hit");
    chk("cache hit done cycle", obs_done, 9);
    model_op(64'hC1, 64'hC2, 64'hC4, 64'hD3, 1'b0);
    run_op(64'hC1, 64'hC2, 64'hC4, 64'hD3, 1'b0);
    check_op("cache miss");
    chk("cache miss transfers", act_q.size(), 7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
